pipe_issue_sched: RTL and testbench

- Issue scheduler for the four-stage register/ALU/memory datapath: regbank[16]x16, memory[256]x16, operand fields rs1/rs2/rd/func/addr.
- Buffers incoming instructions in a small FIFO and issues at most one per cycle.
- Blocks issue on register hazards using a 16-bit busy scoreboard.
- Drops illegal function codes and reports stall statistics.
- Sits between the instruction source and the datapath's operand/function inputs.

---
 rtl/pipe_issue_sched_if.sv | 29 ++
 rtl/pipe_issue_sched.sv | 133 +++++++++++++
 tb/tb_pipe_issue_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_sched_if.sv
// Instruction source and issue channels between the source, the scheduler and the datapath.
interface pipe_issue_sched_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_rs1;
    logic [3:0] in_rs2;
    logic [3:0] in_rd;
    logic [3:0] in_func;
    logic [7:0] in_addr;

    logic       iss_valid;
    logic [3:0] iss_rs1;
    logic [3:0] iss_rs2;
    logic [3:0] iss_rd;
    logic [3:0] iss_func;
    logic [7:0] iss_addr;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        input  in_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        output in_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );
endinterface

// File: rtl/pipe_issue_sched.sv
// In-order issue scheduler: instruction FIFO, busy-register scoreboard with
// writeback-tag pipeline, illegal-func drop and hazard stall counter.
module pipe_issue_sched #(
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned WB_LAT   = 2,
    parameter int unsigned FUNC_MAX = 11
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    pipe_issue_sched_if.slave        bus,
    input  logic                     hold,
    input  logic                     flush,
    output logic [15:0]              busy_mask,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [15:0]              stall_cnt,
    output logic                     err_illegal,
    output logic                     pipe_empty
);
    localparam int unsigned AW    = $clog2(QDEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned EW    = 24;
    localparam int unsigned TAG_D = WB_LAT + 1;

    logic [EW-1:0] q_mem [QDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [EW-1:0] head;
    logic [3:0]    head_rs1, head_rs2, head_rd, head_func;
    logic [7:0]    head_addr;

    logic          head_valid, func_ok, can_go, deps_free;
    logic          issue_c, illegal_c, stall_c, push_c, pop_c;
    logic [15:0]   clr_vec, set_vec, busy_eff;

    logic [TAG_D-1:0] tag_v;
    logic [3:0]       tag_rd [TAG_D];

    assign head      = q_mem[rd_ptr];
    assign head_rs1  = head[23:20];
    assign head_rs2  = head[19:16];
    assign head_rd   = head[15:12];
    assign head_func = head[11:8];
    assign head_addr = head[7:0];

    assign head_valid = (q_count != '0);
    assign func_ok    = (head_func <= 4'(FUNC_MAX));
    assign can_go     = head_valid && !hold && !flush;

    // Writebacks retiring at this edge are already visible to the hazard check
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (tag_v[TAG_D-1]) clr_vec[tag_rd[TAG_D-1]] = 1'b1;
        if (issue_c)        set_vec[head_rd] = 1'b1;
    end

    assign busy_eff  = busy_mask & ~clr_vec;
    assign deps_free = !busy_eff[head_rs1] && !busy_eff[head_rs2] && !busy_eff[head_rd];

    assign illegal_c = can_go && !func_ok;
    assign issue_c   = can_go && func_ok && deps_free;
    assign stall_c   = can_go && func_ok && !deps_free;
    assign pop_c     = issue_c || illegal_c;

    assign bus.in_ready = (q_count < CW'(QDEPTH)) && !flush;
    assign push_c       = bus.in_valid && bus.in_ready;

    assign pipe_empty = (q_count == '0) && (busy_mask == '0) && !bus.iss_valid;

    // Queue storage needs no reset; occupancy and pointers qualify every read
    always_ff @(posedge clk1) begin
        if (push_c) q_mem[wr_ptr] <= {bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func, bus.in_addr};
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            q_count <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_c, pop_c})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Set wins over a same-edge clear of the same register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask <= '0;
            tag_v     <= '0;
            for (int i = 0; i < int'(TAG_D); i++) tag_rd[i] <= '0;
        end else begin
            busy_mask <= busy_eff | set_vec;
            tag_v[0]  <= issue_c;
            tag_rd[0] <= head_rd;
            for (int i = 1; i < int'(TAG_D); i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_rd[i] <= tag_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            bus.iss_valid <= 1'b0;
            bus.iss_rs1   <= '0;
            bus.iss_rs2   <= '0;
            bus.iss_rd    <= '0;
            bus.iss_func  <= '0;
            bus.iss_addr  <= '0;
            err_illegal   <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            bus.iss_valid <= issue_c;
            err_illegal   <= illegal_c;
            if (issue_c) begin
                bus.iss_rs1  <= head_rs1;
                bus.iss_rs2  <= head_rs2;
                bus.iss_rd   <= head_rd;
                bus.iss_func <= head_func;
                bus.iss_addr <= head_addr;
            end
            if (stall_c && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_issue_sched.sv
// Directed bench for pipe_issue_sched: vector table plus hold/flush/reset sequences.
module tb_pipe_issue_sched;
    logic        clk1  = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold  = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] busy_mask, stall_cnt;
    logic [2:0]  q_count;
    logic        err_illegal, pipe_empty;

    int tests = 0;
    int fails = 0;

    pipe_issue_sched_if bus ();

    pipe_issue_sched #(.QDEPTH(4), .WB_LAT(2), .FUNC_MAX(11)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .bus         (bus),
        .hold        (hold),
        .flush       (flush),
        .busy_mask   (busy_mask),
        .q_count     (q_count),
        .stall_cnt   (stall_cnt),
        .err_illegal (err_illegal),
        .pipe_empty  (pipe_empty)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        v;
        logic [3:0]  rs1, rs2, rd, func;
        logic [7:0]  addr;
        logic        e_iss;
        logic [3:0]  e_rd;
        logic [7:0]  e_addr;
        logic [15:0] e_busy;
        logic [2:0]  e_cnt;
        logic [15:0] e_stall;
        logic        e_err;
        logic        e_empty;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [3:0] func, input logic [7:0] addr);
        bus.in_valid = v;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_func  = func;
        bus.in_addr  = addr;
    endtask

    task automatic add(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [3:0] func, input logic [7:0] addr,
                       input logic e_iss, input logic [3:0] e_rd, input logic [7:0] e_addr,
                       input logic [15:0] e_busy, input logic [2:0] e_cnt,
                       input logic [15:0] e_stall, input logic e_err, input logic e_empty);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.func = func; t.addr = addr;
        t.e_iss = e_iss; t.e_rd = e_rd; t.e_addr = e_addr; t.e_busy = e_busy;
        t.e_cnt = e_cnt; t.e_stall = e_stall; t.e_err = e_err; t.e_empty = e_empty;
        vq.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] last_rd;
        logic [7:0] last_addr;

        // v rs1 rs2 rd func addr | iss rd addr busy cnt stall err empty
        // independent pair
        add(1, 3, 5, 10, 0, 125,  0,  0,   0, 16'h0000, 1, 0, 0, 0);
        add(1, 1, 2, 11, 1, 126,  1, 10, 125, 16'h0400, 1, 0, 0, 0);
        add(0, 0, 0,  0, 0,   0,  1, 11, 126, 16'h0C00, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0C00, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0800, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0000, 0, 0, 0, 1);
        // RAW on r10
        add(1, 3, 5, 10, 0, 125,  0,  0,   0, 16'h0000, 1, 0, 0, 0);
        add(1,10, 4, 12, 2, 127,  1, 10, 125, 16'h0400, 1, 0, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0400, 1, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0400, 1, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  1, 12, 127, 16'h1000, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h1000, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h1000, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0000, 0, 2, 0, 1);
        // illegal func 13 dropped, then func 3 issues
        add(1, 1, 2,  4,13,   0,  0,  0,   0, 16'h0000, 1, 2, 0, 0);
        add(1, 5, 6,  7, 3,   9,  0,  0,   0, 16'h0000, 1, 2, 1, 0);
        add(0, 0, 0,  0, 0,   0,  1,  7,   9, 16'h0080, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0080, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0080, 0, 2, 0, 0);
        add(0, 0, 0,  0, 0,   0,  0,  0,   0, 16'h0000, 0, 2, 0, 1);

        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_iss_valid", 32'(bus.iss_valid), 0);
        chk("rst_iss_rd",    32'(bus.iss_rd), 0);
        chk("rst_busy",      32'(busy_mask), 0);
        chk("rst_qcount",    32'(q_count), 0);
        chk("rst_stall",     32'(stall_cnt), 0);
        chk("rst_err",       32'(err_illegal), 0);
        chk("rst_empty",     32'(pipe_empty), 1);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready), 1);

        last_rd   = '0;
        last_addr = '0;
        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].rs1, vq[i].rs2, vq[i].rd, vq[i].func, vq[i].addr);
            tick();
            if (vq[i].e_iss) begin
                last_rd   = vq[i].e_rd;
                last_addr = vq[i].e_addr;
            end
            chk($sformatf("row%0d_iss_valid", i), 32'(bus.iss_valid), 32'(vq[i].e_iss));
            chk($sformatf("row%0d_iss_rd", i),    32'(bus.iss_rd),    32'(last_rd));
            chk($sformatf("row%0d_iss_addr", i),  32'(bus.iss_addr),  32'(last_addr));
            chk($sformatf("row%0d_busy", i),      32'(busy_mask),     32'(vq[i].e_busy));
            chk($sformatf("row%0d_qcount", i),    32'(q_count),       32'(vq[i].e_cnt));
            chk($sformatf("row%0d_stall", i),     32'(stall_cnt),     32'(vq[i].e_stall));
            chk($sformatf("row%0d_err", i),       32'(err_illegal),   32'(vq[i].e_err));
            chk($sformatf("row%0d_empty", i),     32'(pipe_empty),    32'(vq[i].e_empty));
        end

        // fill under hold, fifth offer refused until space frees
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 4'(i + 1), 0, 8'(i));
            tick();
            chk($sformatf("hold_fill%0d_qcount", i), 32'(q_count), 32'(i + 1));
        end
        drive(1, 0, 0, 5, 0, 4);
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk("full_qcount", 32'(q_count), 4);
        chk("full_no_issue", 32'(bus.iss_valid), 0);
        hold = 1'b0;
        tick();
        chk("rel1_iss_valid", 32'(bus.iss_valid), 1);
        chk("rel1_iss_rd",    32'(bus.iss_rd), 1);
        chk("rel1_qcount",    32'(q_count), 3);
        tick();
        chk("rel2_iss_valid", 32'(bus.iss_valid), 1);
        chk("rel2_iss_rd",    32'(bus.iss_rd), 2);
        chk("rel2_qcount",    32'(q_count), 3);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk($sformatf("rel%0d_iss_valid", k), 32'(bus.iss_valid), 1);
            chk($sformatf("rel%0d_iss_rd", k),    32'(bus.iss_rd), 32'(k));
            chk($sformatf("rel%0d_qcount", k),    32'(q_count), 32'(5 - k));
        end
        chk("hold_stall_unchanged", 32'(stall_cnt), 2);
        repeat (4) tick();
        chk("hold_drain_empty", 32'(pipe_empty), 1);

        // flush with r10 in flight and three dependents queued
        drive(1, 0, 0, 10, 0, 0);
        tick();
        drive(1, 10, 0, 1, 0, 0);
        tick();
        chk("fl_x_issue", 32'(bus.iss_valid), 1);
        chk("fl_x_rd",    32'(bus.iss_rd), 10);
        drive(1, 10, 0, 2, 0, 0);
        tick();
        drive(1, 10, 0, 3, 0, 0);
        tick();
        chk("fl_pre_qcount", 32'(q_count), 3);
        chk("fl_pre_busy",   32'(busy_mask), 'h0400);
        chk("fl_pre_stall",  32'(stall_cnt), 4);
        flush = 1'b1;
        drive(1, 0, 0, 5, 0, 0);
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 0);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_qcount",  32'(q_count), 0);
        chk("fl_no_iss",  32'(bus.iss_valid), 0);
        chk("fl_busy",    32'(busy_mask), 0);
        chk("fl_stall",   32'(stall_cnt), 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_post%0d_iss", k), 32'(bus.iss_valid), 0);
        end
        chk("fl_empty", 32'(pipe_empty), 1);

        // asynchronous reset with work queued and a register busy
        drive(1, 0, 0, 9, 0, 0);
        tick();
        drive(1, 9, 0, 1, 0, 0);
        tick();
        hold = 1'b1;
        drive(1, 0, 0, 2, 0, 0);
        tick();
        drive(1, 0, 0, 3, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("mr_pre_qcount", 32'(q_count), 3);
        chk("mr_pre_busy",   32'(busy_mask), 'h0200);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_qcount",    32'(q_count), 0);
        chk("mr_busy",      32'(busy_mask), 0);
        chk("mr_stall",     32'(stall_cnt), 0);
        chk("mr_iss_valid", 32'(bus.iss_valid), 0);
        chk("mr_iss_rd",    32'(bus.iss_rd), 0);
        chk("mr_iss_addr",  32'(bus.iss_addr), 0);
        chk("mr_err",       32'(err_illegal), 0);
        chk("mr_empty",     32'(pipe_empty), 1);
        #2 rst_n = 1'b1;
        hold = 1'b0;
        #1;
        chk("mr_in_ready", 32'(bus.in_ready), 1);
        drive(1, 0, 0, 6, 0, 55);
        tick();
        chk("mr_push_qcount", 32'(q_count), 1);
        chk("mr_push_no_iss", 32'(bus.iss_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("mr_new_iss",  32'(bus.iss_valid), 1);
        chk("mr_new_rd",   32'(bus.iss_rd), 6);
        chk("mr_new_addr", 32'(bus.iss_addr), 55);
        chk("mr_new_busy", 32'(busy_mask), 'h0040);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
